// File: rtl/ebs_regfile_read_arbiter_if.sv
// rtl/ebs_regfile_read_arbiter_if.sv - requester request/response bundle for the regfile read arbiter
interface ebs_regfile_read_arbiter_if #(
    parameter int NR_REQ = 6,
    parameter int XLEN   = 64
);
    logic [NR_REQ-1:0]           req_valid;
    logic [NR_REQ-1:0][4:0]      req_addr;
    logic [NR_REQ-1:0]           req_ready;
    logic [NR_REQ-1:0]           rsp_valid;
    logic [NR_REQ-1:0][XLEN-1:0] rsp_data;
    logic [NR_REQ-1:0]           rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ebs_regfile_read_arbiter.sv
// rtl/ebs_regfile_read_arbiter.sv - round-robin sharing of the four EBS regfile read ports
module ebs_regfile_read_arbiter #(
    parameter int NR_REQ   = 6,
    parameter int NR_SLOTS = 4,
    parameter int XLEN     = 64,
    parameter int CNT_W    = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    ebs_regfile_read_arbiter_if.slave     req_if,
    output logic [NR_SLOTS-1:0][4:0]      regfile_opts_o,
    input  logic [NR_SLOTS-1:0][XLEN-1:0] regfile_data_i,
    output logic [CNT_W-1:0]              conflict_cnt_o
);
    localparam int PTR_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int SLOT_W = $clog2(NR_SLOTS);
    localparam int ECNT_W = $clog2(NR_REQ + NR_SLOTS + 1);

    logic [NR_REQ-1:0]             eligible;
    logic [NR_REQ-1:0]             grant;
    logic [NR_REQ-1:0][SLOT_W-1:0] slot_sel;
    logic [SLOT_W:0]               n_gnt;
    logic [PTR_W:0]                idx;
    logic [PTR_W:0]                ptr_inc;
    logic [PTR_W-1:0]              sel;
    logic [PTR_W-1:0]              last_gnt;
    logic [ECNT_W-1:0]             elig_cnt;

    logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [NR_REQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [NR_REQ-1:0][XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]              conflict_cnt_q, conflict_cnt_d;

    // A full buffer being drained this cycle may accept a new grant.
    assign eligible = req_if.req_valid & (~rsp_valid_q | req_if.rsp_ready)
                    & {NR_REQ{~flush_i & ~rst_i}};

    always_comb begin
        grant          = '0;
        slot_sel       = '0;
        regfile_opts_o = '0;
        n_gnt          = '0;
        idx            = '0;
        sel            = '0;
        last_gnt       = rr_ptr_q;
        ptr_inc        = '0;
        rr_ptr_d       = rr_ptr_q;
        for (int j = 0; j < NR_REQ; j++) begin
            idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(j);
            if (idx >= (PTR_W+1)'(NR_REQ)) begin
                idx = idx - (PTR_W+1)'(NR_REQ);
            end
            sel = idx[PTR_W-1:0];
            if (eligible[sel] && (n_gnt < (SLOT_W+1)'(NR_SLOTS))) begin
                grant[sel]                        = 1'b1;
                slot_sel[sel]                     = n_gnt[SLOT_W-1:0];
                regfile_opts_o[n_gnt[SLOT_W-1:0]] = req_if.req_addr[sel];
                n_gnt                             = n_gnt + (SLOT_W+1)'(1);
                last_gnt                          = sel;
            end
        end
        ptr_inc = {1'b0, last_gnt} + (PTR_W+1)'(1);
        if (|grant) begin
            rr_ptr_d = (ptr_inc == (PTR_W+1)'(NR_REQ)) ? '0 : ptr_inc[PTR_W-1:0];
        end
    end

    always_comb begin
        elig_cnt = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            elig_cnt = elig_cnt + ECNT_W'(eligible[i]);
        end
        conflict_cnt_d = conflict_cnt_q;
        if ((elig_cnt > ECNT_W'(NR_SLOTS)) && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    // Grant wins over a same-cycle drain; flush wins over both.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        for (int i = 0; i < NR_REQ; i++) begin
            if (flush_i) begin
                rsp_valid_d[i] = 1'b0;
            end else if (grant[i]) begin
                rsp_valid_d[i] = 1'b1;
                rsp_data_d[i]  = (req_if.req_addr[i] == 5'd0) ? '0 : regfile_data_i[slot_sel[i]];
            end else if (rsp_valid_q[i] && req_if.rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q       <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign req_if.req_ready = grant;
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_data  = rsp_data_q;
    assign conflict_cnt_o   = conflict_cnt_q;
endmodule
